// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MIPS mult/multu/div/divu unit owning the HI/LO registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] p, step, prod;
  logic [WIDTH-1:0] m, a_mag, b_mag, qf, rf, res_hi, res_lo;
  logic [WIDTH:0] sum, t, diff;
  logic isdiv, neg_q, neg_r, dz, accept, a_neg, b_neg, ge;
  assign busy = state == RUN || state == FIX;
  assign done = state == DN;
  assign accept = start && !busy;
  always_comb begin
    a_neg = !op[0] && srca[WIDTH-1];
    b_neg = !op[0] && srcb[WIDTH-1];
    a_mag = a_neg ? -srca : srca;
    b_mag = b_neg ? -srcb : srcb;
    state_nx = accept ? RUN :
               (state == RUN && cnt == '0) ? FIX :
               state == FIX ? DN :
               state == DN ? IDLE : state;
  end
  // p holds {partial product, multiplier} for mult and {remainder, quotient} for div
  always_comb begin
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    t = p[2*WIDTH-1:WIDTH-1];
    diff = t - {1'b0, m};
    ge = t >= {1'b0, m};
    step = isdiv ? (ge ? {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1} : {p[2*WIDTH-2:0], 1'b0})
                 : {sum, p[WIDTH-1:1]};
    prod = neg_q ? -p : p;
    qf = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    rf = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    res_hi = isdiv ? rf : prod[2*WIDTH-1:WIDTH];
    res_lo = isdiv ? (dz ? '1 : qf) : prod[WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      p <= '0;
      m <= '0;
      isdiv <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        isdiv <= op[1];
        m <= op[1] ? b_mag : a_mag;
        p <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        dz <= srcb == '0;
        cnt <= CW'(WIDTH - 1);
      end else if (state == RUN) begin
        p <= step;
        cnt <= cnt - 1'b1;
      end
      if (state == FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (!busy) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit
module tb_muldiv_unit;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset, start, hi_we, lo_we, busy, done;
  logic [1:0] op;
  logic [W-1:0] srca, srcb, wdata, hi, lo;
  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  always #5 clk = ~clk;
  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv;
    logic [63:0] ua, ub, r;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (o == 2'b00) r = 64'(sa * sbv);
    else if (o == 2'b01) r = ua * ub;
    else if (b == 0) r = {a, 32'hFFFF_FFFF};
    else if (o == 2'b10) r = {32'(sa % sbv), 32'(sa / sbv)};
    else r = {a % b, a / b};
    return r;
  endfunction
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) chk("spurious_done", done, 0);
      else chk("result", {hi, lo}, sb.pop_front());
    end
  end
  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input bit meddle = 0, input bit mthi = 0);
    int lat;
    sb.push_back(model(o, a, b));
    op = o;
    srca = a;
    srcb = b;
    start = 1'b1;
    if (mthi) begin
      hi_we = 1'b1;
      wdata = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    if (mthi) chk("mthi_with_start", hi, 32'hDEAD_BEEF);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (meddle && i == 10) begin
        lo_we = 1'b1;
        wdata = 32'hAA;
        start = 1'b1;
        op = 2'b01;
        srca = 3;
        srcb = 9;
      end else if (meddle && i == 11) begin
        lo_we = 1'b0;
        start = 1'b0;
      end
      if (i == 1 || i == 33) chk("busy_run", busy, 1);
      if (done) lat = i;
    end
    chk("latency", lat, 34);
    chk("busy_done", busy, 0);
  endtask
  task automatic mt(input bit h, input bit l, input logic [31:0] d, input logic [31:0] eh, input logic [31:0] el);
    hi_we = h;
    lo_we = l;
    wdata = d;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    @(negedge clk);
    chk("mt_hi", hi, eh);
    chk("mt_lo", lo, el);
  endtask
  initial begin
    int seen;
    logic [31:0] ra, rb;
    reset = 1'b0;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op = 2'b00;
    srca = '0;
    srcb = '0;
    wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hilo", {hi, lo}, 0);
    reset = 1'b1;
    @(negedge clk);
    mt(1, 0, 32'h55, 32'h55, 32'h0);
    mt(0, 1, 32'h77, 32'h55, 32'h77);
    mt(1, 1, 32'h99, 32'h99, 32'h99);
    op = 2'b00;
    srca = 5;
    srcb = 5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_hilo", {hi, lo}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    run(2'b00, 32'd7, 32'hFFFF_FFFD);
    @(negedge clk);
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(2'b01, 32'd2, 32'd3);
    @(negedge clk);
    run(2'b10, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    run(2'b11, 32'd100, 32'd7);
    @(negedge clk);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge clk);
    run(2'b11, 32'h0000_1234, 32'd0);
    @(negedge clk);
    run(2'b10, 32'hFFFF_FF9C, 32'd0);
    @(negedge clk);
    run(2'b00, 32'h8000_0000, 32'h8000_0000);
    @(negedge clk);
    run(2'b10, 32'd100, 32'hFFFF_FFF9);
    @(negedge clk);
    run(2'b00, 32'd12345, 32'd6789, 1);
    @(negedge clk);
    run(2'b11, 32'd1000, 32'd33, 0, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ra = $urandom;
      rb = (k == 3) ? 32'd0 : $urandom >> (k % 4) * 8;
      run(2'($urandom_range(0, 3)), ra, rb);
    end
    @(negedge clk);
    chk("drain", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
